// File: rtl/hbridge_pkg.sv
// hbridge_pkg: shared state encoding and saturating magnitude helper for the H-bridge driver.
package hbridge_pkg;

    typedef enum logic [1:0] {
        ST_DRIVE = 2'd0,
        ST_DEAD  = 2'd1,
        ST_BRAKE = 2'd2
    } state_t;

    // |x| clipped to 2^m-1, so the most negative command maps onto full scale
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int m);
        logic [31:0] a;
        logic [31:0] lim;
        a   = x[31] ? 32'(-x) : 32'(x);
        lim = (32'd1 << m) - 32'd1;
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// hbridge_channel: per-bridge DRIVE/DEAD/BRAKE FSM, magnitude latch and registered pin outputs.
// HBRIDGE_SLEW_EN limits the per-period magnitude change and ramps to zero before a reversal.
module hbridge_channel
    import hbridge_pkg::*;
#(
    parameter int   NBITS       = 9,
    parameter int   DEAD_CYCLES = 64,
    parameter logic DIR_INV     = 1'b0
`ifdef HBRIDGE_SLEW_EN
    ,
    parameter int   SLEW_STEP   = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [NBITS-2:0] i_cnt,
    input  logic [NBITS-1:0] i_cmd,
    input  logic             i_brake,
    output logic             o_pwm,
    output logic             o_dir,
    output logic             o_br,
    output logic             o_busy
);

    localparam int M  = NBITS - 1;
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DLOAD = DW'(DEAD_CYCLES - 1);

    state_t          r_state, w_state;
    logic [M-1:0]    r_mag, w_mag, w_tmag;
    logic [DW-1:0]   r_dead, w_dead;
    logic            r_dir, w_dir, r_tdir, w_tdir, r_wait, w_wait;
    logic            r_pwm, r_br, w_pwm, w_br;
    logic            w_smp, w_tpin, w_rev;

    assign w_smp  = i_en & i_tick;
    assign w_tmag = M'(abs_sat({{(32-NBITS){i_cmd[NBITS-1]}}, i_cmd}, M));
    assign w_tpin = i_cmd[NBITS-1] ^ DIR_INV;
    assign w_rev  = (w_tmag != '0) & (w_tpin != r_dir);

`ifdef HBRIDGE_SLEW_EN
    localparam logic [M-1:0] STEP = M'(SLEW_STEP);
    logic [M-1:0] w_down, w_ramp;
    assign w_down = (r_mag > STEP) ? r_mag - STEP : '0;
    assign w_ramp = (w_tmag > r_mag) ? ((w_tmag - r_mag > STEP) ? r_mag + STEP : w_tmag)
                                     : ((r_mag - w_tmag > STEP) ? r_mag - STEP : w_tmag);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DRIVE;
            r_mag   <= '0;
            r_dead  <= '0;
            r_dir   <= DIR_INV;
            r_tdir  <= DIR_INV;
            r_wait  <= 1'b0;
            r_pwm   <= 1'b0;
            r_br    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_mag   <= w_mag;
            r_dead  <= w_dead;
            r_dir   <= w_dir;
            r_tdir  <= w_tdir;
            r_wait  <= w_wait;
            r_pwm   <= w_pwm;
            r_br    <= w_br;
        end
    end

    // r_tdir holds the pin value DIR takes when the dead time expires
    always_comb begin
        w_state = r_state;
        w_mag   = r_mag;
        w_dead  = r_dead;
        w_dir   = r_dir;
        w_tdir  = r_tdir;
        w_wait  = r_wait;
        if (i_en) begin
            case (r_state)
                ST_DRIVE: begin
                    if (i_brake) begin
                        w_state = ST_BRAKE;
                    end else if (w_smp) begin
                        w_wait = 1'b0;
`ifdef HBRIDGE_SLEW_EN
                        w_mag = w_rev ? w_down : w_ramp;
                        if (w_rev && r_mag == '0) begin
`else
                        w_mag = w_tmag;
                        if (w_rev) begin
`endif
                            w_state = ST_DEAD;
                            w_dead  = DLOAD;
                            w_tdir  = w_tpin;
                        end
                    end
                end
                ST_DEAD: begin
                    if (i_brake) begin
                        w_state = ST_BRAKE;
                    end else begin
                        if (w_smp && w_tmag != '0)
                            w_tdir = w_tpin;
`ifndef HBRIDGE_SLEW_EN
                        if (w_smp)
                            w_mag = w_tmag;
`endif
                        if (r_dead == '0) begin
                            w_state = ST_DRIVE;
                            w_dir   = w_tdir;
                            w_wait  = ~w_smp;
                        end else begin
                            w_dead = r_dead - 1'b1;
                        end
                    end
                end
                ST_BRAKE: begin
                    if (!i_brake) begin
                        w_state = ST_DRIVE;
                        w_mag   = '0;
                        w_wait  = 1'b0;
                    end
                end
                default: w_state = ST_DRIVE;
            endcase
        end
    end

    // LMD18200 brake needs PWM held high alongside BRAKE
    always_comb begin
        w_br  = i_en & (w_state == ST_BRAKE);
        w_pwm = i_en & ((w_state == ST_BRAKE) | ((w_state == ST_DRIVE) & ~w_wait & (i_cnt < w_mag)));
    end

    assign o_pwm  = r_pwm;
    assign o_br   = r_br;
    assign o_dir  = r_dir;
    assign o_busy = (r_state == ST_DEAD);

endmodule

// File: rtl/hbridge_driver.sv
// hbridge_driver: NCHAN-channel PWM/DIR/BRAKE driver for LMD18200-class bridges with a shared period counter.
// Define HBRIDGE_SLEW_EN to enable per-period magnitude slew limiting (SLEW_STEP).
module hbridge_driver #(
    parameter int               NCHAN       = 2,
    parameter int               NBITS       = 9,
    parameter int               CLK_DIV     = 1,
    parameter int               DEAD_CYCLES = 64,
    parameter logic [NCHAN-1:0] DIR_INV     = '0
`ifdef HBRIDGE_SLEW_EN
    ,
    parameter int               SLEW_STEP   = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCHAN*NBITS-1:0] cmd_i,
    input  logic [NCHAN-1:0]       brake_i,
    output logic [NCHAN-1:0]       pwm_o,
    output logic [NCHAN-1:0]       dir_o,
    output logic [NCHAN-1:0]       br_o,
    output logic [NCHAN-1:0]       busy_o,
    output logic                   period_o
);

    localparam int M  = NBITS - 1;
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [M-1:0]  CMAX  = M'((1 << M) - 2);
    localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [M-1:0]  r_cnt;
    logic          r_period;
    logic          w_adv;

    assign w_adv = en & (r_pre == PLAST);

    // period_o marks the first clk of each period, i.e. the cycle cnt has just wrapped to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre    <= '0;
            r_cnt    <= '0;
            r_period <= 1'b0;
        end else begin
            if (en)
                r_pre <= w_adv ? '0 : r_pre + 1'b1;
            if (w_adv)
                r_cnt <= (r_cnt == CMAX) ? '0 : r_cnt + 1'b1;
            r_period <= w_adv & (r_cnt == CMAX);
        end
    end

    assign period_o = r_period;

    for (genvar k = 0; k < NCHAN; k++) begin : gen_ch
        hbridge_channel #(
            .NBITS      (NBITS),
            .DEAD_CYCLES(DEAD_CYCLES),
            .DIR_INV    (DIR_INV[k])
`ifdef HBRIDGE_SLEW_EN
            ,
            .SLEW_STEP  (SLEW_STEP)
`endif
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_en   (en),
            .i_tick (r_period),
            .i_cnt  (r_cnt),
            .i_cmd  (cmd_i[k*NBITS +: NBITS]),
            .i_brake(brake_i[k]),
            .o_pwm  (pwm_o[k]),
            .o_dir  (dir_o[k]),
            .o_br   (br_o[k]),
            .o_busy (busy_o[k])
        );
    end

endmodule

// File: doc/hbridge_driver.md
Name: hbridge_driver

Overview:
- Multi-channel successor to the single LMD18200 driver.
- Converts NCHAN signed duty commands into PWM/DIR/BRAKE pin triples for LMD18200-class H-bridges.
- Adds three things the single-channel driver lacks: a shared period counter with glitch-free duty update, enforced dead time on direction reversal, and a per-channel brake request.
- Sits between the motor-control loop (speed/position PID outputs) and the FPGA motor pins.

Parameters:
- NCHAN, 2: number of bridge channels.
- NBITS, 9: signed command width including sign. Magnitude width M = NBITS-1.
- CLK_DIV, 1: clk cycles per PWM counter tick (≥1). Sets PWM frequency = f_clk / (CLK_DIV·(2^M−1)).
- DEAD_CYCLES, 64: clk cycles of forced PWM-low before the DIR pin flips (≥1).
- DIR_INV, {NCHAN{1'b0}}: per-channel bit mask that inverts dir_o for mirrored motor mounting.
- SLEW_STEP, 4: maximum magnitude change per PWM period. Used only when HBRIDGE_SLEW_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable. When low, all pwm_o=0 and br_o=0; counters and states hold.
- cmd_i  in  NCHAN·NBITS  packed signed commands, channel k at [k·NBITS +: NBITS]
- brake_i  in  NCHAN  per-channel brake request
- pwm_o  out  NCHAN  PWM pin
- dir_o  out  NCHAN  direction pin
- br_o  out  NCHAN  brake pin
- busy_o  out  NCHAN  high while the channel is in DEAD state
- period_o  out  1  one-cycle pulse at each period start (cnt wraps to 0)

Behaviour:
- Reset: all outputs 0, period counter 0, prescaler 0, every channel in DRIVE with latched magnitude 0 and dir_o = DIR_INV[k].
- Period counter:
  - Advances once every CLK_DIV clk cycles, while en is high only.
  - Counts 0..2^M−2, then wraps; period_o pulses at the wrap.
- Command sampling:
  - Each channel samples cmd_i only on the period_o cycle, so mid-period changes never glitch the output.
  - mag = |cmd|. cmd = −2^M saturates to 2^M−1. Sign s = cmd[NBITS−1]. Zero is treated as s = current direction, so no reversal is triggered.
- PWM output: pwm_o = (cnt < mag_latched) in DRIVE. This gives 0% at mag=0 and 100% at mag=2^M−1. pwm_o is registered, so there is 1 cycle of latency from cnt to pin.
- Per-channel FSM states: DRIVE, DEAD, BRAKE.
  - DRIVE → BRAKE: when brake_i is high (this has priority over everything).
  - DRIVE → DEAD: on the sample cycle, when mag ≠ 0 and s ^ DIR_INV[k] ≠ dir_o.
  - DEAD: pwm_o=0, busy_o=1, dead counter loads DEAD_CYCLES and decrements every clk.
  - DEAD → DRIVE: at count 0, dir_o ← s ^ DIR_INV[k] in the same cycle. PWM resumes at the next period start with the latched magnitude.
  - BRAKE: br_o=1 and pwm_o=1 (the LMD18200 requires PWM high for brake), dir_o held.
  - BRAKE → DRIVE: when brake_i falls, with mag_latched forced to 0 until the next sample. A direction change at release still passes through DEAD.
- Simultaneous events:
  - brake_i during DEAD: abort to BRAKE; dir_o is unchanged.
  - A new sample while in DEAD is latched, but the dead count does not restart.
  - A reversal back to the original sign during DEAD still completes DEAD; dir_o then keeps its old value.
- en low: the FSM freezes, pwm_o=0, br_o=0, dir_o held, and the dead counter is paused.
- rst mid-DEAD or mid-BRAKE returns the channel to the reset values immediately.

Optional Feature:
- HBRIDGE_SLEW_EN defined:
  - On each sample, mag_latched moves toward the target by at most SLEW_STEP.
  - A reversal first ramps to 0. DEAD is entered only when mag_latched=0 and the target sign differs; the ramp up then starts from 0.
- Not defined: mag_latched = target directly (step response).

Decomposition:
- Package hbridge_pkg holds:
  - the state encoding (ST_DRIVE=2'd0, ST_DEAD=2'd1, ST_BRAKE=2'd2);
  - a function for |x| with saturation.
- Sub-module hbridge_channel holds the per-channel FSM, magnitude latch, slew logic, and output registers. It takes cnt, period tick, and en from the top.
- The top level holds the prescaler, the shared counter, and the generate loop over NCHAN.

Test Plan (all cases use NCHAN=2, NBITS=9, CLK_DIV=1, DEAD_CYCLES=64):
1. cmd0=+128 held → pwm_o[0] high for exactly 128 of every 255 cycles; dir_o[0]=0; br_o=0.
2. cmd0=+100 then −100 mid-period → pwm_o[0] low from the next period start for 64 cycles, busy_o[0]=1, dir_o[0] flips at the end of DEAD, then 100/255 duty resumes at the following period.
3. cmd0=−256 → saturated to 255, pwm_o[0] constantly high, dir_o[0]=1. With DIR_INV=2'b01 the same command gives dir_o[0]=0.
4. brake_i[1] asserted during DEAD of channel 1 → next cycle br_o[1]=1, pwm_o[1]=1, dir_o[1] unchanged. On release, pwm_o[1]=0 until the next period_o.
5. en=0 for 300 cycles mid-DEAD → all pwm_o/br_o=0, dead count holds. After en=1 the remaining dead cycles complete.
6. HBRIDGE_SLEW_EN with SLEW_STEP=4: cmd +20 → −20 → magnitude 16, 12, 8, 4, 0 per period, then DEAD, then 4, 8, … with dir_o=1.
